// File: rtl/undertale_pkg.sv
// Shared types and widths for the player HP path.
package undertale_pkg;

  localparam int HP_W = 16;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hp_state_t;

endpackage

// File: rtl/hp_drain_ctr.sv
// Displayed-HP register: steps one unit per frame tick toward the true HP.
module hp_drain_ctr
  import undertale_pkg::*;
#(
  parameter int MAX_HP = 20
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_restart,
  input  logic            i_frame_tick,
  input  logic [HP_W-1:0] i_target,
  output logic [HP_W-1:0] o_disp
);

  logic [HP_W-1:0] disp_q;
  logic [HP_W-1:0] disp_d;

  always_comb begin
    disp_d = disp_q;
    if (i_restart) begin
      disp_d = HP_W'(MAX_HP);
    end else if (i_frame_tick) begin
      if (disp_q > i_target) begin
        disp_d = disp_q - HP_W'(1);
      end else if (disp_q < i_target) begin
        disp_d = disp_q + HP_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      disp_q <= HP_W'(MAX_HP);
    end else begin
      disp_q <= disp_d;
    end
  end

  assign o_disp = disp_q;

endmodule

// File: rtl/hp_controller.sv
// Player HP state: damage/heal with saturation, i-frames and death FSM.
// Optional displayed-HP animation is enabled with the HP_DRAIN_EN macro.
module hp_controller
  import undertale_pkg::*;
#(
  parameter int MAX_HP       = 20,
  parameter int IFRAME_TICKS = 30,
  parameter int AMT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_restart,
  input  logic             i_hit,
  input  logic [AMT_W-1:0] i_dmg,
  input  logic             i_heal,
  input  logic [AMT_W-1:0] i_heal_amt,
  input  logic             i_frame_tick,
  output logic [HP_W-1:0]  o_total_hp,
  output logic [HP_W-1:0]  o_remain_hp,
  output logic [HP_W-1:0]  o_true_hp,
  output logic             o_invuln,
  output logic             o_dead,
  output logic             o_hit_ack
);

  localparam int CTR_W = (IFRAME_TICKS > 1) ? $clog2(IFRAME_TICKS + 1) : 1;

  hp_state_t       state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [HP_W-1:0] true_hp_q, true_hp_d;
  logic            hit_ack_q, hit_ack_d;

  // One spare bit catches underflow on damage and overflow on heal.
  logic [HP_W:0]   dmg_diff;
  logic [HP_W:0]   heal_sum;

  assign dmg_diff = {1'b0, true_hp_q} - (HP_W + 1)'(i_dmg);
  assign heal_sum = {1'b0, true_hp_q} + (HP_W + 1)'(i_heal_amt);

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    true_hp_d = true_hp_q;
    hit_ack_d = 1'b0;

    if (i_restart) begin
      state_d   = ALIVE;
      ctr_d     = '0;
      true_hp_d = HP_W'(MAX_HP);
    end else begin
      // A hit always shadows a same-cycle heal, even when the hit is ignored.
      if (i_hit) begin
        if (state_q == ALIVE) begin
          hit_ack_d = 1'b1;
          true_hp_d = dmg_diff[HP_W] ? '0 : dmg_diff[HP_W-1:0];
          if (true_hp_d == '0) begin
            state_d = DEAD;
          end else if (IFRAME_TICKS > 0) begin
            state_d = INVULN;
            ctr_d   = CTR_W'(IFRAME_TICKS);
          end
        end
      end else if (i_heal && state_q != DEAD) begin
        if (heal_sum > (HP_W + 1)'(MAX_HP)) begin
          true_hp_d = HP_W'(MAX_HP);
        end else begin
          true_hp_d = heal_sum[HP_W-1:0];
        end
      end

      if (state_q == INVULN && i_frame_tick) begin
        ctr_d = (ctr_q == '0) ? '0 : ctr_q - CTR_W'(1);
        if (ctr_q <= CTR_W'(1)) begin
          state_d = ALIVE;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ALIVE;
      ctr_q     <= '0;
      true_hp_q <= HP_W'(MAX_HP);
      hit_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      true_hp_q <= true_hp_d;
      hit_ack_q <= hit_ack_d;
    end
  end

`ifdef HP_DRAIN_EN
  // Drain compares against the registered (pre-update) true HP.
  hp_drain_ctr #(
    .MAX_HP(MAX_HP)
  ) u_drain (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_restart   (i_restart),
    .i_frame_tick(i_frame_tick),
    .i_target    (true_hp_q),
    .o_disp      (o_remain_hp)
  );
`else
  assign o_remain_hp = true_hp_q;
`endif

  assign o_total_hp = HP_W'(MAX_HP);
  assign o_true_hp  = true_hp_q;
  assign o_invuln   = (state_q == INVULN);
  assign o_dead     = (state_q == DEAD);
  assign o_hit_ack  = hit_ack_q;

endmodule

// File: doc/hp_controller.md
# hp_controller

Owns the player's hit-point state. Accepts damage and heal events from the battle logic and applies invulnerability frames after each accepted hit. Produces the total and displayed remaining HP values that feed the HP bar renderer, with the displayed value stepping one unit per frame toward the true value. It sits between the collision/battle FSM and the HP bar geometry block.

## Interface
- MAX_HP, 20: total HP. Must be ≥1, so the downstream bar divide is never by zero.
- IFRAME_TICKS, 30: frame ticks of invulnerability after an accepted hit; 0 disables invulnerability.
- AMT_W, 8: width of damage/heal amounts.
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_restart  in  1  synchronous pulse; restores full HP
- i_hit  in  1  damage request pulse
- i_dmg  in  AMT_W  damage amount, sampled with i_hit
- i_heal  in  1  heal request pulse
- i_heal_amt  in  AMT_W  heal amount, sampled with i_heal
- i_frame_tick  in  1  one-cycle pulse per video frame
- o_total_hp  out  16  constant MAX_HP
- o_remain_hp  out  16  displayed HP (drained)
- o_true_hp  out  16  actual HP
- o_invuln  out  1  high while in INVULN
- o_dead  out  1  high in DEAD
- o_hit_ack  out  1  one-cycle pulse per accepted hit

## Operation
- States:
  - ALIVE: hits are accepted.
  - INVULN: hits are ignored and o_hit_ack stays 0; heals are still accepted.
  - DEAD: hits and heals are ignored.
- Reset values:
  - true HP = MAX_HP; displayed HP = MAX_HP
  - state = ALIVE; invuln counter = 0
  - o_invuln = 0, o_dead = 0, o_hit_ack = 0
- Accepted hit:
  - true HP becomes max(true − i_dmg, 0), computed at 17 bits and saturated.
  - o_hit_ack pulses for one cycle.
  - If the new HP is 0, next state is DEAD.
  - Else, if IFRAME_TICKS > 0, next state is INVULN with the counter loaded to IFRAME_TICKS.
  - Else the state stays ALIVE.
- i_dmg = 0 with i_hit: the hit is still accepted (ack pulse, i-frames start); HP is unchanged.
- Heal: true HP becomes min(true + i_heal_amt, MAX_HP).
- INVULN counter:
  - Decrements on each i_frame_tick.
  - On the tick that takes it 1→0, the state returns to ALIVE on the same edge.
- Priority, highest first: i_restart > i_hit > i_heal.
  - When a hit and a heal arrive in the same cycle, the heal is dropped, even if the hit itself is ignored because of INVULN.
- i_restart in any state:
  - true HP = MAX_HP; displayed HP = MAX_HP
  - state = ALIVE; counter = 0
  - Any i_hit/i_heal/i_frame_tick in that cycle is discarded.
- Drain, on i_frame_tick only:
  - displayed > true: displayed −1
  - displayed < true: displayed +1
  - equal: unchanged
- i_frame_tick coinciding with a hit or heal: the drain compares against the pre-update true HP.
- DEAD asserts as soon as true HP reaches 0; it does not wait for the displayed HP to reach 0. The displayed HP keeps draining while DEAD.

## Timing
- All outputs are registered. o_total_hp is a constant.
- Event sampled at edge N: o_true_hp, o_hit_ack, o_invuln and o_dead are valid after edge N.
- o_remain_hp changes only on edges where i_frame_tick = 1; one step per tick.
- A full drain from MAX_HP to 0 takes MAX_HP frame ticks.
- An async i_rst mid-drain or mid-INVULN forces the reset values immediately, with no clock required.
- Input pulses longer than one cycle count as one event per cycle. Callers must pulse.

## Configuration
- HP_DRAIN_EN
  - Defined: displayed HP animates as described in Operation.
  - Undefined: the drain logic is removed and o_remain_hp equals o_true_hp every cycle (same register). All other behaviour is unchanged.

## Structure
- Shared package undertale_pkg holds:
  - the hp_state_t enum {ALIVE, INVULN, DEAD}
  - HP_W = 16
- One sub-module, hp_drain_ctr: the displayed-HP register and step logic, instantiated only under HP_DRAIN_EN.
- The FSM, saturating arithmetic and i-frame counter live in hp_controller.

## Test plan
- Reset, then 3 frame ticks → o_true_hp = o_remain_hp = 20; o_invuln = 0; o_dead = 0; o_total_hp = 20.
- i_hit, dmg = 5 → o_true_hp = 15 next cycle and o_hit_ack pulses once. o_invuln = 1 for exactly 30 frame ticks. o_remain_hp reaches 15 after 5 ticks.
- Second i_hit, dmg = 5, during INVULN → o_true_hp stays 15 and there is no ack. Same hit after INVULN ends → o_true_hp = 10.
- i_hit dmg = 3 and i_heal 10 in the same cycle, from true HP 10 → o_true_hp = 7. Later heal 200 → o_true_hp = 20 (saturated).
- i_hit dmg = 255 from 20 → o_true_hp = 0 and o_dead = 1. Subsequent heals are ignored. i_restart → o_true_hp = o_remain_hp = 20; o_dead = 0.
- Assert i_rst asynchronously between clock edges during drain from 20 to 12 → outputs return to reset values before the next edge. Rerun the bench with HP_DRAIN_EN undefined → o_remain_hp equals o_true_hp every cycle.
